// File: rtl/ahb_arb_pkg.sv
// ============================================================================
// Module   : ahb_arb_pkg
// Brief    : AHB transfer/burst encodings and arbitration constants shared by
//            the output-stage arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_arb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Beats remaining after the NONSEQ beat of a defined-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        logic [3:0] v_beats;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  v_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  v_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: v_beats = 4'd15;
            default:                      v_beats = 4'd0;
        endcase
        return v_beats;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_arb_rr_pick.sv
// ============================================================================
// Module   : ahb_arb_rr_pick
// Brief    : Combinational rotating priority picker; the first request
//            strictly after ptr (wrapping) wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arb_rr_pick #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_ID_W = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_ID_W-1:0] ptr,
    output logic [PORT_ID_W-1:0] win,
    output logic                 valid
);

    int w_dist;
    int w_best;

    // Distance of port k from the pointer is (k - ptr - 1) mod NUM_PORTS;
    // the requester with the smallest distance wins.
    always_comb begin
        win    = '0;
        valid  = 1'b0;
        w_dist = 0;
        w_best = NUM_PORTS;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_dist = k - int'(ptr) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_PORTS;
            end
            if (req[k] && (w_dist < w_best)) begin
                w_best = w_dist;
                win    = PORT_ID_W'(k);
                valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_out_arb_param.sv
// ============================================================================
// Module   : ahb_out_arb_param
// Brief    : Per-slave output-stage arbiter with fixed or round-robin priority,
//            defined-length burst protection and locked-transfer hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_out_arb_param
    import ahb_arb_pkg::*;
#(
    parameter int                   NUM_PORTS = 5,
    parameter int                   PORT_ID_W = 3,
    parameter int                   ARB_MODE  = 0,
    parameter logic [NUM_PORTS-1:0] PORT_MASK = {NUM_PORTS{1'b1}}
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_ID_W-1:0] addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    localparam logic [PORT_ID_W-1:0] c_LAST_PORT = PORT_ID_W'(NUM_PORTS - 1);

    logic [PORT_ID_W-1:0] r_addr;
    logic                 r_no_port;
    logic [PORT_ID_W-1:0] r_ptr;
    logic [3:0]           r_beat;

    logic                 w_active;
    logic                 w_continue;
    logic                 w_hold;
    logic                 w_accept;
    logic [NUM_PORTS-1:0] w_cur_onehot;
    logic [NUM_PORTS-1:0] w_eff_req;
    logic [PORT_ID_W-1:0] w_pick_ptr;
    logic [PORT_ID_W-1:0] w_win;
    logic                 w_valid;
    logic [PORT_ID_W-1:0] w_addr_nxt;
    logic                 w_no_port_nxt;
    logic [PORT_ID_W-1:0] w_ptr_nxt;
    logic [3:0]           w_beat_nxt;

    assign w_active     = HSELM & (HTRANSM != HTRANS_IDLE);
    assign w_cur_onehot = NUM_PORTS'(1) << r_addr;
    // The current owner keeps competing while it still has a live transfer.
    assign w_eff_req    = (req_port & PORT_MASK)
                        | (w_cur_onehot & {NUM_PORTS{w_active & ~r_no_port}});
    assign w_pick_ptr   = (ARB_MODE == ARB_RR) ? r_ptr : c_LAST_PORT;

    ahb_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_ID_W (PORT_ID_W)
    ) u_pick (
        .req   (w_eff_req),
        .ptr   (w_pick_ptr),
        .win   (w_win),
        .valid (w_valid)
    );

    assign w_continue = ~r_no_port & HSELM
                      & ((HTRANSM == HTRANS_BUSY) | (HTRANSM == HTRANS_SEQ));
    assign w_hold     = HMASTLOCKM | (burst_hold & w_active) | w_continue;

    always_comb begin
        w_addr_nxt    = r_addr;
        w_no_port_nxt = r_no_port;
        w_ptr_nxt     = r_ptr;
        if (!w_hold) begin
            if (w_valid) begin
                w_addr_nxt    = w_win;
                w_no_port_nxt = 1'b0;
                if ((w_win != r_addr) || r_no_port) begin
                    w_ptr_nxt = w_win;
                end
            end else if (HSELM) begin
                w_no_port_nxt = 1'b0;
            end else begin
                w_no_port_nxt = 1'b1;
            end
        end
    end

    assign w_accept = HREADYM & HSELM & ~r_no_port;

    always_comb begin
        w_beat_nxt = r_beat;
        if (w_accept) begin
            case (HTRANSM)
                HTRANS_NONSEQ: w_beat_nxt = burst_beats(HBURSTM);
                HTRANS_SEQ:    w_beat_nxt = (r_beat != 4'd0) ? (r_beat - 4'd1) : 4'd0;
                HTRANS_IDLE:   w_beat_nxt = 4'd0;
                default:       w_beat_nxt = r_beat;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_addr    <= '0;
            r_no_port <= 1'b1;
            r_ptr     <= c_LAST_PORT;
            r_beat    <= 4'd0;
        end else begin
            if (HREADYM) begin
                r_addr    <= w_addr_nxt;
                r_no_port <= w_no_port_nxt;
                r_ptr     <= w_ptr_nxt;
            end
            r_beat <= w_beat_nxt;
        end
    end

    assign addr_in_port = r_addr;
    assign no_port      = r_no_port;
    assign burst_hold   = (r_beat != 4'd0);

endmodule

`default_nettype wire

// File: tb/tb_ahb_out_arb_param.sv
// ============================================================================
// Module   : tb_ahb_out_arb_param
// Brief    : Self-checking bench: fixed, round-robin and masked instances
//            share stimulus and are compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_out_arb_param;

    localparam int NP = 5;

    logic       HCLK;
    logic       HRESET;
    logic [4:0] req_port;
    logic       HREADYM;
    logic       HSELM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic       HMASTLOCKM;

    logic [2:0] o_addr [3];
    logic       o_np   [3];
    logic       o_bh   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    // Instance 0: fixed priority, 1: round-robin, 2: fixed with ports 0/1 unconnected.
    int         c_mode [3] = '{0, 1, 0};
    logic [4:0] c_mask [3] = '{5'b11111, 5'b11111, 5'b11100};

    int m_addr  [3];
    bit m_none  [3];
    int m_ptr   [3];
    int m_beats [3];

    ahb_out_arb_param #(.NUM_PORTS(NP), .PORT_ID_W(3), .ARB_MODE(0), .PORT_MASK(5'b11111)) u_dut_fix (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
        .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(o_addr[0]), .no_port(o_np[0]), .burst_hold(o_bh[0]));

    ahb_out_arb_param #(.NUM_PORTS(NP), .PORT_ID_W(3), .ARB_MODE(1), .PORT_MASK(5'b11111)) u_dut_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
        .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(o_addr[1]), .no_port(o_np[1]), .burst_hold(o_bh[1]));

    ahb_out_arb_param #(.NUM_PORTS(NP), .PORT_ID_W(3), .ARB_MODE(0), .PORT_MASK(5'b11100)) u_dut_msk (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
        .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(o_addr[2]), .no_port(o_np[2]), .burst_hold(o_bh[2]));

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic int burst_len(logic [2:0] hb);
        case (hb)
            3'b010, 3'b011: return 3;
            3'b100, 3'b101: return 7;
            3'b110, 3'b111: return 15;
            default:        return 0;
        endcase
    endfunction

    function automatic bit wants(int k, int p, bit act);
        logic [4:0] r;
        r = req_port & c_mask[k];
        if (((r >> p) & 5'd1) != 5'd0) return 1'b1;
        return (p == m_addr[k]) && act && !m_none[k];
    endfunction

    // Reference: one rising edge worth of behaviour for instance k.
    function automatic void model_step(int k);
        bit act;
        int old_beats, base, win, cand;
        if (HRESET) begin
            m_addr[k] = 0; m_none[k] = 1'b1; m_ptr[k] = NP - 1; m_beats[k] = 0;
            return;
        end
        act       = HSELM && (HTRANSM != 2'b00);
        old_beats = m_beats[k];
        if (HREADYM && HSELM && !m_none[k]) begin
            if (HTRANSM == 2'b10)      m_beats[k] = burst_len(HBURSTM);
            else if (HTRANSM == 2'b11) m_beats[k] = (m_beats[k] > 0) ? m_beats[k] - 1 : 0;
            else if (HTRANSM == 2'b00) m_beats[k] = 0;
        end
        if (!HREADYM || HMASTLOCKM) return;
        if (old_beats != 0 && act) return;
        if (!m_none[k] && HSELM && (HTRANSM == 2'b01 || HTRANSM == 2'b11)) return;
        base = (c_mode[k] == 1) ? m_ptr[k] : NP - 1;
        win  = -1;
        for (int j = 1; j <= NP; j++) begin
            cand = (base + j) % NP;
            if (win < 0 && wants(k, cand, act)) win = cand;
        end
        if (win >= 0) begin
            if (win != m_addr[k] || m_none[k]) m_ptr[k] = win;
            m_addr[k] = win;
            m_none[k] = 1'b0;
        end else begin
            m_none[k] = !HSELM;
        end
    endfunction

    task automatic cycle();
        @(posedge HCLK);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic idle_inputs();
        req_port = 5'b0; HREADYM = 1'b1; HSELM = 1'b0;
        HTRANSM = 2'b00; HBURSTM = 3'b000; HMASTLOCKM = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        HRESET = 1'b1;
        cycle();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        HRESET = 1'b1;
        cycle();
        cycle();
        HRESET = 1'b0;
        cycle();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (o_addr[k] !== 3'd0) begin n_fail++; $display("FAIL reset_addr[%0d]: got %0d want 0", k, o_addr[k]); end
            n_cmp++; if (o_np[k] !== 1'b1) begin n_fail++; $display("FAIL reset_no_port[%0d]: got %0b want 1", k, o_np[k]); end
            n_cmp++; if (o_bh[k] !== 1'b0) begin n_fail++; $display("FAIL reset_burst_hold[%0d]: got %0b want 0", k, o_bh[k]); end
        end
        req_port = 5'b00100;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd2) begin n_fail++; $display("FAIL first_grant_addr: got %0d want 2", o_addr[0]); end
        n_cmp++; if (o_np[0] !== 1'b0) begin n_fail++; $display("FAIL first_grant_no_port: got %0b want 0", o_np[0]); end
    endtask

    task automatic test_fixed_priority();
        HSELM = 1'b0; HTRANSM = 2'b00; req_port = 5'b11010;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd1) begin n_fail++; $display("FAIL fixed_lowest: got %0d want 1", o_addr[0]); end
        HSELM = 1'b1; HTRANSM = 2'b00; req_port = 5'b11000;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd3) begin n_fail++; $display("FAIL fixed_next: got %0d want 3", o_addr[0]); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_port = 5'b11111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_cmp++;
            if (o_addr[1] !== 3'(i % NP)) begin
                n_fail++; $display("FAIL rr_grant_%0d: got %0d want %0d", i, o_addr[1], i % NP);
            end
        end
    endtask

    task automatic test_burst_protect();
        apply_reset();
        req_port = 5'b00100;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd2) begin n_fail++; $display("FAIL burst_setup: got %0d want 2", o_addr[0]); end
        HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b011;
        cycle();
        n_cmp++; if (o_bh[0] !== 1'b1) begin n_fail++; $display("FAIL burst_hold_nonseq: got %0b want 1", o_bh[0]); end
        req_port = 5'b00101; HTRANSM = 2'b11;
        for (int b = 0; b < 3; b++) begin
            cycle();
            n_cmp++; if (o_addr[0] !== 3'd2) begin n_fail++; $display("FAIL burst_owner_%0d: got %0d want 2", b, o_addr[0]); end
            n_cmp++; if (o_bh[0] !== (b < 2)) begin n_fail++; $display("FAIL burst_hold_seq_%0d: got %0b want %0b", b, o_bh[0], b < 2); end
        end
        HTRANSM = 2'b00;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd0) begin n_fail++; $display("FAIL burst_release: got %0d want 0", o_addr[0]); end
    endtask

    task automatic test_lock();
        apply_reset();
        req_port = 5'b01000;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd3) begin n_fail++; $display("FAIL lock_setup: got %0d want 3", o_addr[0]); end
        HMASTLOCKM = 1'b1; req_port = 5'b00001; HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b000;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_cmp++; if (o_addr[0] !== 3'd3) begin n_fail++; $display("FAIL lock_hold_%0d: got %0d want 3", i, o_addr[0]); end
        end
        HMASTLOCKM = 1'b0; HTRANSM = 2'b00;
        cycle();
        n_cmp++; if (o_addr[0] !== 3'd0) begin n_fail++; $display("FAIL lock_release: got %0d want 0", o_addr[0]); end
    endtask

    task automatic test_mask_and_reset();
        apply_reset();
        req_port = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (o_np[2] !== 1'b1) begin n_fail++; $display("FAIL mask_no_port_%0d: got %0b want 1", i, o_np[2]); end
        end
        req_port = 5'b00100;
        cycle();
        n_cmp++; if (o_addr[2] !== 3'd2) begin n_fail++; $display("FAIL mask_grant: got %0d want 2", o_addr[2]); end
        HSELM = 1'b1; HTRANSM = 2'b10; HBURSTM = 3'b101;
        cycle();
        n_cmp++; if (o_bh[2] !== 1'b1) begin n_fail++; $display("FAIL mask_burst_start: got %0b want 1", o_bh[2]); end
        HTRANSM = 2'b11;
        cycle();
        n_cmp++; if (o_bh[2] !== 1'b1) begin n_fail++; $display("FAIL mask_burst_mid: got %0b want 1", o_bh[2]); end
        HRESET = 1'b1;
        cycle();
        HRESET = 1'b0;
        n_cmp++; if (o_addr[2] !== 3'd0) begin n_fail++; $display("FAIL midburst_reset_addr: got %0d want 0", o_addr[2]); end
        n_cmp++; if (o_np[2] !== 1'b1) begin n_fail++; $display("FAIL midburst_reset_no_port: got %0b want 1", o_np[2]); end
        n_cmp++; if (o_bh[2] !== 1'b0) begin n_fail++; $display("FAIL midburst_reset_hold: got %0b want 0", o_bh[2]); end
        n_cmp++; if (o_bh[0] !== 1'b0) begin n_fail++; $display("FAIL midburst_reset_hold_fix: got %0b want 0", o_bh[0]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            HRESET     = ($urandom_range(0, 199) == 0);
            req_port   = 5'($urandom);
            HREADYM    = ($urandom_range(0, 3) != 0);
            HSELM      = ($urandom_range(0, 3) != 0);
            HTRANSM    = 2'($urandom);
            HBURSTM    = 3'($urandom);
            HMASTLOCKM = ($urandom_range(0, 9) == 0);
            cycle();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (o_addr[k] !== 3'(m_addr[k]) || o_np[k] !== m_none[k] || o_bh[k] !== (m_beats[k] != 0)) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: got addr=%0d np=%0b bh=%0b want addr=%0d np=%0b bh=%0b",
                             i, k, o_addr[k], o_np[k], o_bh[k], m_addr[k], m_none[k], m_beats[k] != 0);
                end
            end
        end
        HRESET = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_addr[k] = 0; m_none[k] = 1'b1; m_ptr[k] = NP - 1; m_beats[k] = 0;
        end
        HRESET = 1'b1;
        idle_inputs();
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_burst_protect();
        test_lock();
        test_mask_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ahb_out_arb_param.md
Name: ahb_out_arb_param

Overview:
- Parametrised output-stage arbiter for the AHB bus matrix. There is one instance per slave port.
- Selects which input port drives the shared slave, from NUM_PORTS requesters with sparse connectivity (PORT_MASK).
- Supports fixed-priority or round-robin mode.
- Adds defined-length burst protection: a granted INCR4/8/16 or WRAP4/8/16 burst is never split. HMASTLOCKM hold is kept from the previous generation.

Parameters:
- NUM_PORTS, 5: number of input ports. Legal range 2..8.
- PORT_ID_W, 3: width of addr_in_port. Requirement: 2**PORT_ID_W >= NUM_PORTS.
- ARB_MODE, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.
- PORT_MASK, {NUM_PORTS{1'b1}}: bit k = 1 means port k is connected to this slave. Unconnected requests are ignored.

Ports:
- HCLK  in  1  AHB system clock.
- HRESET  in  1  Reset. Synchronous, active-high.
- req_port  in  NUM_PORTS  Per-port request. Bit k = port k.
- HREADYM  in  1  Slave-side transfer done.
- HSELM  in  1  Slave select of the currently granted port.
- HTRANSM  in  2  Transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HBURSTM  in  3  Burst type.
- HMASTLOCKM  in  1  Locked transfer.
- addr_in_port  out  PORT_ID_W  Index of the selected port.
- no_port  out  1  High means no port is selected.
- burst_hold  out  1  High while a defined-length burst is in progress (beat counter != 0).

Behaviour:
- One clock, HCLK. All state updates on the HCLK rising edge.
- Reset, HRESET=1 at a rising edge:
  - addr_in_port = 0, no_port = 1, burst_hold = 0.
  - beat counter = 0.
  - RR pointer = NUM_PORTS-1, so port 0 wins the first RR search.
  - Reset overrides everything, including mid-burst and mid-lock.
- Registered state (addr_in_port, no_port, RR pointer) updates only when HREADYM=1; otherwise it holds. Grant latency from req_port to addr_in_port is 1 cycle with HREADYM=1.
- active = HSELM & (HTRANSM != IDLE).
- eff_req = (req_port & PORT_MASK) | (onehot(addr_in_port) & {NUM_PORTS{active & ~no_port}}).
- Priority of next-grant decision, first match wins:
  1. HMASTLOCKM=1: hold addr_in_port and no_port.
  2. burst_hold=1 and active: hold.
  3. ~no_port & HSELM & HTRANSM in {BUSY, SEQ}: hold. This covers undefined-length INCR continuation.
  4. eff_req != 0:
     - ARB_MODE=0: lowest set index.
     - ARB_MODE=1: first set index strictly after the RR pointer, wrapping NUM_PORTS-1 -> 0.
     - no_port_next = 0. The RR pointer loads the winner only when the winner differs from the current port or no_port was 1.
  5. HSELM=1: hold current port, no_port = 0.
  6. Otherwise: no_port = 1, addr_in_port unchanged.
- Beat counter, 4-bit. "Accepted" means HREADYM & HSELM & ~no_port.
  - Accepted NONSEQ loads: INCR4/WRAP4 (010/011) -> 3; INCR8/WRAP8 (100/101) -> 7; INCR16/WRAP16 (110/111) -> 15; SINGLE/INCR -> 0.
  - Accepted SEQ with counter > 0: decrement. The counter never underflows.
  - Accepted IDLE: clear to 0 (early termination).
  - BUSY: hold the counter.
  - burst_hold = (counter != 0).
- Boundary conditions:
  - Requests from masked ports never win and never appear in eff_req.
  - Simultaneous lock and burst end: lock keeps the hold.
  - All ports requesting in RR mode: each port is granted once per NUM_PORTS arbitration decisions.
  - Out-of-range addr_in_port values are unreachable.

Decomposition:
- Package ahb_arb_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HBURST encodings.
  - ARB_FIXED = 0, ARB_RR = 1.
  - Function burst_beats(hburst), returning the counter load value.
- Sub-module ahb_arb_rr_pick: combinational rotate-and-priority picker. Inputs are the request vector and pointer; outputs are the winner index and a valid flag. It is used in both modes, with pointer = NUM_PORTS-1 forced for fixed priority.

Test Plan:
1. Reset release, no requests, HSELM=0 -> no_port=1, addr_in_port=0. Then req_port=5'b00100 with HREADYM=1 -> next cycle addr_in_port=2, no_port=0.
2. ARB_MODE=0, req_port=5'b11010 -> addr_in_port=1. Drop bit 1 with HTRANSM=IDLE -> addr_in_port=3.
3. ARB_MODE=1, req_port=5'b11111 held, port IDLE after each grant -> grants 0,1,2,3,4,0 on successive HREADYM cycles.
4. Port 2 granted, NONSEQ with HBURSTM=3'b011, then req_port[0]=1 during 3 SEQ beats -> addr_in_port stays 2 and burst_hold=1 for 3 cycles. Port 0 is granted on the cycle after the last beat.
5. HMASTLOCKM=1 with port 3 granted and req_port=5'b00001 for 4 cycles -> addr_in_port=3 throughout. Deassert lock -> addr_in_port=0.
6. PORT_MASK=5'b11100, req_port=5'b00011 -> no_port stays 1. Assert HRESET mid-burst -> addr_in_port=0, no_port=1, burst_hold=0 at the next edge.
